// File: rtl/pc_next_unit.sv
// pc_next_unit
//   Registered program counter for the fetch stage. Computes pc+4 and
//   the branch target pc+4+(sext(imm)<<2). Each cycle it picks the next pc
//   from these sources, highest priority first:
//   stall > return > jump/call > taken branch > sequential.
//   A small circular return-address stack (RAS) serves jal / jr $ra.
//
// Ports
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   stall           hold pc, RAS and sticky flags this cycle
//   branch_taken    resolved conditional branch for the instruction at pc
//   imm             signed branch offset, counted in instructions
//   is_jump         j/jal at pc
//   jump_index      instruction index field of j/jal
//   is_call         jal: push pc+4 (only acted on together with is_jump)
//   is_ret          jr $ra: pop the RAS into pc
//   pc              current fetch address (registered)
//   pcplus4         pc+4 (combinational)
//   pcbranch        branch target (combinational)
//   ras_empty/full  RAS occupancy status
//   ras_overflow    sticky: push while full (oldest entry was lost)
//   ras_underflow   sticky: pop while empty
module pc_next_unit #(
  parameter int              XLEN      = 32,
  parameter int              IMM_W     = 16,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int              RAS_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [IMM_W-1:0]   imm,
  input  logic               is_jump,
  input  logic [XLEN-7:0]    jump_index,
  input  logic               is_call,
  input  logic               is_ret,
  output logic [XLEN-1:0]    pc,
  output logic [XLEN-1:0]    pcplus4,
  output logic [XLEN-1:0]    pcbranch,
  output logic               ras_empty,
  output logic               ras_full,
  output logic               ras_overflow,
  output logic               ras_underflow
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  logic [XLEN-1:0]  pc_reg;
  logic [PTR_W-1:0] top_reg;
  logic [CNT_W-1:0] count_reg;
  logic             overflow_reg;
  logic             underflow_reg;

  // Return addresses. Storage carries no reset: count_reg alone decides
  // which entries are valid.
  logic [XLEN-1:0]  ras_mem [RAS_DEPTH];

  logic [XLEN-1:0]  branch_off;
  logic [XLEN-1:0]  jump_target;
  logic [XLEN-1:0]  ras_top;
  logic [PTR_W-1:0] wr_ptr;

  logic [XLEN-1:0]  pc_next;
  logic             push_en;
  logic             pop_en;
  logic             set_overflow;
  logic             set_underflow;

  // Sign-extended offset scaled to bytes. When IMM_W == XLEN-2 there are
  // no extension bits left to replicate.
  generate
    if (IMM_W < XLEN - 2) begin : g_sext
      assign branch_off = {{(XLEN-IMM_W-2){imm[IMM_W-1]}}, imm, 2'b00};
    end else begin : g_nosext
      assign branch_off = {imm, 2'b00};
    end
  endgenerate

  assign pcplus4     = pc_reg + XLEN'(4);
  assign pcbranch    = pcplus4 + branch_off;
  assign jump_target = {pcplus4[XLEN-1:XLEN-4], jump_index, 2'b00};

  assign ras_top     = ras_mem[top_reg];
  // Power-of-two depth: the pointer wraps naturally. When the stack is
  // full, top+1 is exactly the oldest entry, so a push overwrites it.
  assign wr_ptr      = top_reg + PTR_W'(1);

  assign ras_empty     = (count_reg == '0);
  assign ras_full      = (count_reg == CNT_W'(RAS_DEPTH));
  assign ras_overflow  = overflow_reg;
  assign ras_underflow = underflow_reg;
  assign pc            = pc_reg;

  // Next-pc selection in priority order.
  always_comb begin
    pc_next       = pcplus4;
    push_en       = 1'b0;
    pop_en        = 1'b0;
    set_overflow  = 1'b0;
    set_underflow = 1'b0;
    if (stall) begin
      pc_next = pc_reg;
    end else if (is_ret) begin
      if (!ras_empty) begin
        pc_next = ras_top;
        pop_en  = 1'b1;
      end else begin
        set_underflow = 1'b1;
      end
    end else if (is_jump) begin
      pc_next = jump_target;
      if (is_call) begin
        push_en      = 1'b1;
        set_overflow = ras_full;
      end
    end else if (branch_taken) begin
      pc_next = pcbranch;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg        <= RESET_PC;
      top_reg       <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      pc_reg <= pc_next;
      if (push_en) begin
        top_reg <= wr_ptr;
        if (!ras_full) begin
          count_reg <= count_reg + CNT_W'(1);
        end
      end else if (pop_en) begin
        top_reg   <= top_reg - PTR_W'(1);
        count_reg <= count_reg - CNT_W'(1);
      end
      if (set_overflow) begin
        overflow_reg <= 1'b1;
      end
      if (set_underflow) begin
        underflow_reg <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) begin
      ras_mem[wr_ptr] <= pcplus4;
    end
  end

endmodule

// File: tb/tb_pc_next_unit.sv
// Directed-vector bench for pc_next_unit. A queue-based reference model
// tracks pc, the return stack and the sticky flags; a compare process
// checks every output against it on each falling edge. Literal checks pin
// the model to hand-computed addresses.
module tb_pc_next_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [15:0] imm = '0;
  logic        is_jump = 1'b0;
  logic [25:0] jump_index = '0;
  logic        is_call = 1'b0;
  logic        is_ret = 1'b0;
  logic [31:0] pc, pcplus4, pcbranch;
  logic        ras_empty, ras_full, ras_overflow, ras_underflow;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  // Reference model state
  logic [31:0] m_pc = '0;
  logic [31:0] m_ras[$];
  bit          m_over = 1'b0;
  bit          m_under = 1'b0;

  pc_next_unit dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken),
    .imm(imm), .is_jump(is_jump), .jump_index(jump_index),
    .is_call(is_call), .is_ret(is_ret), .pc(pc), .pcplus4(pcplus4),
    .pcbranch(pcbranch), .ras_empty(ras_empty), .ras_full(ras_full),
    .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] model_branch();
    int off;
    off = int'($signed(imm)) * 4;
    return m_pc + 32'd4 + 32'(off);
  endfunction

  task automatic model_reset();
    m_pc = 32'h0;
    m_ras.delete();
    m_over = 1'b0;
    m_under = 1'b0;
  endtask

  // Apply one cycle of inputs; the model advances after the edge using the
  // same (still held) inputs.
  task automatic step(input logic s, input logic br, input logic [15:0] im,
                      input logic j, input logic [25:0] ji,
                      input logic c, input logic r);
    logic [31:0] p4;
    stall = s; branch_taken = br; imm = im;
    is_jump = j; jump_index = ji; is_call = c; is_ret = r;
    @(posedge clk);
    cyc++;
    p4 = m_pc + 32'd4;
    if (s) begin
      // hold everything
    end else if (r) begin
      if (m_ras.size() > 0) m_pc = m_ras.pop_back();
      else begin m_pc = p4; m_under = 1'b1; end
    end else if (j) begin
      if (c) begin
        m_ras.push_back(p4);
        if (m_ras.size() > DEPTH) begin
          void'(m_ras.pop_front());
          m_over = 1'b1;
        end
      end
      m_pc = (p4 & 32'hF000_0000) | (32'(ji) << 2);
    end else if (br) begin
      m_pc = model_branch();
    end else begin
      m_pc = p4;
    end
    #1;
  endtask

  task automatic idle();
    step(0, 0, 16'h0, 0, 26'h0, 0, 0);
  endtask

  task automatic jump_to(input logic [31:0] addr);
    step(0, 0, 16'h0, 1, 26'(addr >> 2), 0, 0);
  endtask

  task automatic ret();
    step(0, 0, 16'h0, 0, 26'h0, 0, 1);
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      $display("cyc %0d pc=%h p4=%h pb=%h empty=%0b full=%0b ovf=%0b unf=%0b",
               cyc, pc, pcplus4, pcbranch, ras_empty, ras_full, ras_overflow, ras_underflow);
      chk("pc", pc, m_pc);
      chk("pcplus4", pcplus4, m_pc + 32'd4);
      chk("pcbranch", pcbranch, model_branch());
      chk("ras_empty", 32'(ras_empty), 32'(m_ras.size() == 0));
      chk("ras_full", 32'(ras_full), 32'(m_ras.size() == DEPTH));
      chk("ras_overflow", 32'(ras_overflow), 32'(m_over));
      chk("ras_underflow", 32'(ras_underflow), 32'(m_under));
    end
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    rst_n = 1'b1;
    chk_en = 1'b1;
    chk("reset_pc", pc, 32'h0);

    // Sequential fetch
    idle(); chk("seq_4", pc, 32'h4);
    idle(); chk("seq_8", pc, 32'h8);
    idle(); chk("seq_c", pc, 32'hC);

    // Branches around 0x100
    jump_to(32'h100); chk("jump_100", pc, 32'h100);
    imm = 16'h0003; #1;
    chk("pcbranch_lit", pcbranch, 32'h110);
    step(0, 1, 16'h0003, 0, 26'h0, 0, 0); chk("br_plus3", pc, 32'h110);
    step(0, 1, 16'hFFFF, 0, 26'h0, 0, 0); chk("br_minus1", pc, 32'h110);
    step(0, 1, 16'hFFFE, 0, 26'h0, 0, 0); chk("br_minus2", pc, 32'h10C);

    // Asynchronous reset mid-cycle
    #2 rst_n = 1'b0;
    model_reset();
    #1 chk("async_reset_pc", pc, 32'h0);
    chk("async_reset_empty", 32'(ras_empty), 32'h1);
    @(negedge clk); #1;
    rst_n = 1'b1;

    // Wrap: branch back from 0 lands at 0xFFFF_FFFC, then sequential wraps
    step(0, 1, 16'hFFFE, 0, 26'h0, 0, 0); chk("br_to_top", pc, 32'hFFFF_FFFC);
    chk("wrap_pcplus4", pcplus4, 32'h0);
    idle(); chk("wrap_pc", pc, 32'h0);

    // Call / return
    jump_to(32'h0040_0010); chk("jump_400010", pc, 32'h0040_0010);
    step(0, 0, 16'h0, 1, 26'h010_0040, 1, 0); chk("call_target", pc, 32'h0040_0100);
    ret(); chk("ret_addr", pc, 32'h0040_0014);
    chk("ret_empty", 32'(ras_empty), 32'h1);

    // Five calls into a four-entry stack
    for (int k = 0; k < 5; k++) begin
      jump_to(32'hA0 + 32'(k) * 32'h10 - 32'd4);
      step(0, 0, 16'h0, 1, 26'h80, 1, 0);
    end
    chk("ovf_full", 32'(ras_full), 32'h1);
    chk("ovf_flag", 32'(ras_overflow), 32'h1);
    ret(); chk("ret_e0", pc, 32'hE0);
    ret(); chk("ret_d0", pc, 32'hD0);
    ret(); chk("ret_c0", pc, 32'hC0);
    ret(); chk("ret_b0", pc, 32'hB0);
    ret(); chk("ret_under_pc", pc, 32'hB4);
    chk("under_flag", 32'(ras_underflow), 32'h1);

    // Stall holds everything
    step(0, 0, 16'h0, 1, 26'h80, 1, 0); chk("call_200", pc, 32'h200);
    for (int k = 0; k < 3; k++) begin
      step(1, 1, 16'h0010, 1, 26'h1234, 1, 1);
      chk("stall_pc", pc, 32'h200);
    end
    chk("stall_not_full", 32'(ras_full), 32'h0);

    // Return beats a simultaneous jump/call
    step(0, 0, 16'h0, 1, 26'h1234, 1, 1); chk("ret_over_jump", pc, 32'hB8);
    chk("ret_over_jump_empty", 32'(ras_empty), 32'h1);
    idle(); chk("after_ret_seq", pc, 32'hBC);

    @(negedge clk); #1;
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pc_next_unit.md
Name: pc_next_unit

Overview:
Registered program-counter generator for the MIPS core. It is the sequential successor to the combinational branch-target adder. It holds the PC and computes PC+4 and the branch target PC+4+(sext(imm)<<2). It selects the next PC among sequential, branch, jump and return, and keeps a small return-address stack (RAS) for call/return. It sits at the front of the fetch stage and drives the instruction-memory address.

Parameters:
XLEN, 32, address/PC width in bits (must be >= 8)
IMM_W, 16, branch immediate width before sign extension (IMM_W <= XLEN-2)
RESET_PC, 32'h0000_0000, PC value loaded on reset (bits [1:0] must be 0)
RAS_DEPTH, 4, return-address stack entries (power of two, >= 2)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
stall  input  1  hold PC and RAS this cycle
branch_taken  input  1  resolved beq/bne taken for the instruction at pc
imm  input  IMM_W  branch offset in instructions (signed)
is_jump  input  1  j/jal at pc
jump_index  input  XLEN-6  instruction index field
is_call  input  1  jal: push return address (only honoured with is_jump)
is_ret  input  1  jr $ra: pop RAS
pc  output  XLEN  current fetch address (registered)
pcplus4  output  XLEN  pc+4, combinational, modulo 2^XLEN
pcbranch  output  XLEN  pcplus4 + (sext(imm)<<2), combinational, modulo 2^XLEN
ras_empty  output  1  RAS holds no entries
ras_full  output  1  RAS holds RAS_DEPTH entries
ras_overflow  output  1  sticky: push occurred while full
ras_underflow  output  1  sticky: pop occurred while empty

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC; RAS count=0 and top pointer=0; ras_overflow=0; ras_underflow=0. This applies immediately, mid-operation included. The first edge after deassertion performs a normal update.
- Arithmetic: sext(imm) extends to XLEN, then shifts left 2 with bits [1:0]=0. All adds wrap modulo 2^XLEN with no carry out. Jump target = {pcplus4[XLEN-1:XLEN-4], jump_index, 2'b00}.
- Next-PC priority, each rising edge:
  - stall=1: hold pc, RAS and flags, ignoring all other inputs.
  - is_ret=1: if RAS is non-empty, pc<=top entry and pop. If RAS is empty, pc<=pcplus4 and set ras_underflow.
  - is_jump=1: pc<=jump target. If is_call=1, also push pcplus4.
  - branch_taken=1: pc<=pcbranch.
  - Otherwise: pc<=pcplus4.
- is_call without is_jump is ignored. Simultaneous is_ret and is_jump: ret wins, with no push and no jump. Branch is ignored if any higher-priority source is active.
- RAS is a circular buffer of RAS_DEPTH entries, XLEN bits each.
  - Push when not full: write at top+1, count+1.
  - Push when full: overwrite the oldest entry (pointer wraps), count stays RAS_DEPTH, set ras_overflow.
  - Pop: read top, top-1 (wrapping), count-1.
- ras_empty = (count==0). ras_full = (count==RAS_DEPTH). Both are combinational from registered state.
- Latency: next-PC selection takes effect on pc one cycle after inputs are sampled. pcplus4/pcbranch follow pc and imm combinationally in the same cycle.
- Sticky flags clear only on reset.

Test Plan:
- Reset then 3 free cycles -> pc = 0x0, 0x4, 0x8, 0xC. Assert rst_n=0 asynchronously mid-cycle -> pc=0x0 without waiting for a clock edge.
- pc=0x100, imm=16'h0003, branch_taken=1 -> pcbranch=0x110 and next pc=0x110. imm=16'hFFFF at pc=0x110 -> pc=0x110; imm=16'hFFFE at pc=0x110 -> pc=0x10C.
- Wrap: pc=0xFFFF_FFFC, no control -> pcplus4=0x0, next pc=0x0.
- pc=0x0040_0010, is_jump=1, is_call=1, jump_index=0x010_0040 -> pc=0x0040_0100, RAS top=0x0040_0014. Then is_ret=1 -> pc=0x0040_0014, ras_empty=1.
- With RAS_DEPTH=4, do 5 calls with returns 0xA0, 0xB0, 0xC0, 0xD0, 0xE0 -> ras_full=1 and ras_overflow=1. Then 4 rets yield 0xE0, 0xD0, 0xC0, 0xB0. A 5th ret -> pc=pcplus4 and ras_underflow=1.
- stall=1 with branch_taken=1, is_call=1 and is_jump=1 held 3 cycles -> pc and RAS unchanged. Ret + jump in the same cycle -> ret taken, no push.
